// File: rtl/call_return_ctrl_if.sv
// Request, PC-redirect and stack-port bundle between the control unit, call_return_ctrl and the word stack.
interface call_return_ctrl_if #(
  parameter int WORD_RANGE = 8,
  parameter int WORD_COUNT = 64,
  parameter int ADDR_WIDTH = 16
);
  localparam int DW = $clog2(WORD_COUNT + 1);

  logic                  Call;
  logic                  Ret;
  logic [ADDR_WIDTH-1:0] Ret_addr;
  logic [ADDR_WIDTH-1:0] Target_addr;
  logic [WORD_RANGE-1:0] Stk_data_out;
  logic                  Stk_full;
  logic                  Stk_empty;
  logic                  Stk_enable;
  logic                  Stk_push;
  logic                  Stk_pop;
  logic [WORD_RANGE-1:0] Stk_data_in;
  logic                  Busy;
  logic                  Pc_load;
  logic [ADDR_WIDTH-1:0] Next_pc;
  logic [DW-1:0]         Depth;
  logic                  Err_ovf;
  logic                  Err_unf;

  modport slave (
    input  Call, Ret, Ret_addr, Target_addr, Stk_data_out, Stk_full, Stk_empty,
    output Stk_enable, Stk_push, Stk_pop, Stk_data_in, Busy, Pc_load, Next_pc,
           Depth, Err_ovf, Err_unf
  );

  modport master (
    output Call, Ret, Ret_addr, Target_addr, Stk_data_out, Stk_full, Stk_empty,
    input  Stk_enable, Stk_push, Stk_pop, Stk_data_in, Busy, Pc_load, Next_pc,
           Depth, Err_ovf, Err_unf
  );
endinterface

// File: rtl/call_return_ctrl.sv
// CALL/RET sequencer: spills a return address onto the word stack as NW words and
// restores it on return, redirecting the PC via a one-cycle Pc_load pulse.
module call_return_ctrl #(
  parameter int WORD_RANGE = 8,
  parameter int WORD_COUNT = 64,
  parameter int ADDR_WIDTH = 16
) (
  input logic              Clk,
  input logic              RstN,
  call_return_ctrl_if.slave bus
);
  localparam int NW = ADDR_WIDTH / WORD_RANGE;
  localparam int DW = $clog2(WORD_COUNT + 1);
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP, S_CAPT, S_DONE} state_t;

  state_t                r_state;
  logic [KW-1:0]         r_k;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_tgt;
  logic [ADDR_WIDTH-1:0] r_next_pc;
  logic [WORD_RANGE-1:0] r_data_in;
  logic [DW-1:0]         r_depth;
  logic                  r_push, r_pop, r_busy, r_pc_load, r_err_ovf, r_err_unf;
  logic                  w_last;
  logic                  w_pop;

  assign w_last = (r_k == KW'(NW - 1));
  // A pop against an empty stack is suppressed in the same cycle; the FSM aborts on that edge.
  assign w_pop  = r_pop & ~bus.Stk_empty;

  assign bus.Stk_push    = r_push;
  assign bus.Stk_pop     = w_pop;
  assign bus.Stk_enable  = r_push | w_pop;
  assign bus.Stk_data_in = r_data_in;
  assign bus.Busy        = r_busy;
  assign bus.Pc_load     = r_pc_load;
  assign bus.Next_pc     = r_next_pc;
  assign bus.Depth       = r_depth;
  assign bus.Err_ovf     = r_err_ovf;
  assign bus.Err_unf     = r_err_unf;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_addr    <= '0;
      r_tgt     <= '0;
      r_next_pc <= '0;
      r_data_in <= '0;
      r_depth   <= '0;
      r_push    <= 1'b0;
      r_pop     <= 1'b0;
      r_busy    <= 1'b0;
      r_pc_load <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      r_pc_load <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.Call) begin
            if ((int'(r_depth) + NW > WORD_COUNT) || bus.Stk_full) begin
              r_err_ovf <= 1'b1;
            end else begin
              r_state   <= S_PUSH;
              r_push    <= 1'b1;
              r_busy    <= 1'b1;
              r_k       <= '0;
              r_data_in <= bus.Ret_addr[WORD_RANGE-1:0];
              r_addr    <= bus.Ret_addr >> WORD_RANGE;
              r_tgt     <= bus.Target_addr;
            end
          end else if (bus.Ret) begin
            if ((int'(r_depth) < NW) || bus.Stk_empty) begin
              r_err_unf <= 1'b1;
            end else begin
              r_state <= S_POP;
              r_pop   <= 1'b1;
              r_busy  <= 1'b1;
              r_k     <= '0;
              r_addr  <= '0;
            end
          end
        end
        S_PUSH: begin
          r_depth <= r_depth + DW'(1);
          if (w_last) begin
            r_push    <= 1'b0;
            r_data_in <= '0;
            r_next_pc <= r_tgt;
            r_pc_load <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_k       <= r_k + KW'(1);
            r_data_in <= r_addr[WORD_RANGE-1:0];
            r_addr    <= r_addr >> WORD_RANGE;
          end
        end
        S_POP: begin
          if (bus.Stk_empty) begin
            r_pop     <= 1'b0;
            r_busy    <= 1'b0;
            r_err_unf <= 1'b1;
            r_depth   <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_depth <= r_depth - DW'(1);
            // Data_out lags its pop by one cycle, so each edge after the first captures the previous word.
            if (r_k != '0)
              r_addr <= (r_addr << WORD_RANGE) | ADDR_WIDTH'(bus.Stk_data_out);
            if (w_last) begin
              r_pop   <= 1'b0;
              r_state <= S_CAPT;
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        S_CAPT: begin
          r_next_pc <= (r_addr << WORD_RANGE) | ADDR_WIDTH'(bus.Stk_data_out);
          r_pc_load <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
